// File: rtl/thumb_fetch.sv
// Thumb prefetch: fetches 32-bit words, splits them into little-endian halfwords, queues and streams them on cmd.
// Latency: first halfword is valid at the edge that samples imem_ack (one cycle after req with zero-wait memory).
// Backpressure: a fetch issues only while the queue has room for a whole word; cmd/cmd_pc hold while cmd_ready is low.
module thumb_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sck,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [15:0] cmd,
    output logic [31:0] cmd_pc,
    output logic        cmd_valid,
    input  logic        cmd_ready
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   hpc_q, hpc_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   q_q [DEPTH];
    logic [15:0]   q_d [DEPTH];
    logic          drop_q, drop_d;
    logic          skip_lo_q, skip_lo_d;
    logic          valid_q, valid_d;

    logic          pop;
    logic          ack;
    logic          push_ok;
    logic [1:0]    push_n;
    logic [CW-1:0] base;

    // State register: queue is a shift register so entry 0 is always the head and drives cmd directly.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            fpc_q     <= {RESET_PC[31:2], 2'b00};
            hpc_q     <= {RESET_PC[31:1], 1'b0};
            addr_q    <= {RESET_PC[31:2], 2'b00};
            cnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= 16'h0000;
            end
            drop_q    <= 1'b0;
            skip_lo_q <= RESET_PC[1];
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            hpc_q     <= hpc_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            drop_q    <= drop_d;
            skip_lo_q <= skip_lo_d;
            valid_q   <= valid_d;
        end
    end

    // Next state: redirect flushes and retargets, otherwise pop/push the queue; then decide whether to fetch.
    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        hpc_d     = hpc_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        drop_d    = drop_q;
        skip_lo_d = skip_lo_q;

        pop     = valid_q && cmd_ready;
        ack     = (state_q == S_WAIT) && imem_ack;
        push_ok = ack && !drop_q && !redirect;
        push_n  = push_ok ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;
        base    = cnt_q - CW'(pop);

        if (redirect) begin
            // A head popped this cycle is older than the branch and counts as consumed.
            cnt_d     = '0;
            hpc_d     = redirect_pc & 32'hFFFF_FFFE;
            fpc_d     = redirect_pc & 32'hFFFF_FFFC;
            skip_lo_d = redirect_pc[1];
            // An in-flight fetch that is not answered this edge returns stale data later.
            drop_d    = (state_q == S_WAIT) && !imem_ack;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    q_d[i] = q_q[i + 1];
                end
                hpc_d = hpc_q + 32'd2;
            end
            if (ack) begin
                drop_d = 1'b0;
            end
            if (push_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == base) begin
                        q_d[i] = skip_lo_q ? imem_rdata[31:16] : imem_rdata[15:0];
                    end else if (!skip_lo_q && (CW'(i) == base + CW'(1))) begin
                        q_d[i] = imem_rdata[31:16];
                    end
                end
                skip_lo_d = 1'b0;
            end
            cnt_d = base + CW'(push_n);
        end

        // A new fetch may start from IDLE or right behind an ack; a pending drop keeps WAIT until its ack.
        if ((state_q == S_IDLE) || ack) begin
            if (int'(cnt_d) + 2 <= DEPTH) begin
                state_d = S_WAIT;
                addr_d  = fpc_d;
                fpc_d   = fpc_d + 32'd4;
            end else begin
                state_d = S_IDLE;
            end
        end

        valid_d = (cnt_d != '0);
    end

    assign imem_req  = (state_q == S_WAIT);
    assign imem_addr = addr_q;
    assign cmd       = q_q[0];
    assign cmd_pc    = hpc_q;
    assign cmd_valid = valid_q;

endmodule

// File: tb/tb_thumb_fetch.sv
module tb_thumb_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        sck = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [15:0] cmd;
    logic [31:0] cmd_pc;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int wait_fix = 0;      // >= 0: fixed wait states; -1: random 0..wait_max
    int wait_max = 0;
    int req_starts = 0;
    int hs_count = 0;
    logic [31:0] req_log[$];
    logic [31:0] exp_q[$];  // expected cmd_pc stream; cmd derived from memory image
    logic [31:0] fill_pc;

    thumb_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .sck(sck), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .cmd(cmd), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
    );

    always #5 sck = ~sck;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'hBBBB_AAAA;
        if (a == 32'h0000_0004) return 32'hDDDD_CCCC;
        return {a[15:0] ^ 16'hC3A5, a[31:16] + a[15:0] + 16'h1111};
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word(pc & 32'hFFFF_FFFC);
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(fill_pc);
            fill_pc = fill_pc + 32'd2;
        end
    endtask

    task automatic step();
        @(posedge sck);
        #2;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        req_log.delete();
        step();
        redirect    = 1'b0;
    endtask

    // Memory responder: one outstanding request, wait states chosen per request.
    initial begin
        int          wcnt;
        logic        pend;
        logic [31:0] held;
        wcnt = 0;
        pend = 1'b0;
        held = 32'h0;
        forever begin
            @(posedge sck);
            #1;
            imem_ack = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (imem_req) begin
                if (!pend) begin
                    pend = 1'b1;
                    held = imem_addr;
                    req_log.push_back(imem_addr);
                    req_starts++;
                    wcnt = (wait_fix >= 0) ? wait_fix : int'($urandom_range(wait_max, 0));
                end else begin
                    check("addr_stable", imem_addr, held);
                end
                check("addr_align", imem_addr & 32'h3, 32'h0);
                if (wcnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    pend       = 1'b0;
                end else begin
                    wcnt--;
                    imem_rdata = $urandom;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Monitor: compares every accepted halfword against the expected stream and checks stall stability.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_cmd;
        logic [31:0] prev_pc;
        logic [31:0] e;
        prev_stall = 1'b0;
        prev_cmd   = 16'h0;
        prev_pc    = 32'h0;
        forever begin
            @(negedge sck);
            if (!rst_n) begin
                exp_q.delete();
                fill_pc    = RESET_PC & 32'hFFFF_FFFE;
                refill();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(cmd_valid), 32'h1);
                    check("hold_cmd", 32'(cmd), 32'(prev_cmd));
                    check("hold_pc", cmd_pc, prev_pc);
                end
                if (cmd_valid && cmd_ready) begin
                    e = exp_q.pop_front();
                    check("cmd_pc", cmd_pc, e);
                    check("cmd", 32'(cmd), 32'(hw_at(e)));
                    hs_count++;
                    refill();
                end
                prev_stall = cmd_valid && !cmd_ready && !redirect;
                prev_cmd   = cmd;
                prev_pc    = cmd_pc;
                if (redirect) begin
                    exp_q.delete();
                    fill_pc = redirect_pc & 32'hFFFF_FFFE;
                    refill();
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        int          seen;
        int          base_hs;
        logic [31:0] old_addr;

        // Reset state
        #12;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, RESET_PC & 32'hFFFF_FFFC);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_valid", 32'(cmd_valid), 32'h0);
        check("rst_cmd_pc", cmd_pc, RESET_PC & 32'hFFFF_FFFE);

        // Reset fetch with zero-wait memory
        @(negedge sck);
        rst_n = 1'b1;
        @(negedge sck);
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", log_at(0), 32'h0);
        @(negedge sck);
        check("first_valid", 32'(cmd_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge sck);
            check("stream_valid", 32'(cmd_valid), 32'h1);
        end

        // Backpressure: only two fetches fit a DEPTH=4 queue
        step();
        cmd_ready = 1'b0;
        do_redirect(32'h0000_0000);
        repeat (12) step();
        @(negedge sck);
        check("bp_nreq", 32'(req_log.size()), 32'd2);
        check("bp_req0", log_at(0), 32'h0);
        check("bp_req1", log_at(1), 32'h4);
        check("bp_req_low", 32'(imem_req), 32'h0);
        check("bp_cmd", 32'(cmd), 32'h0000_AAAA);
        check("bp_valid", 32'(cmd_valid), 32'h1);
        step();
        cmd_ready = 1'b1;
        repeat (10) step();

        // Odd redirect: low halfword of the first word is skipped
        do_redirect(32'h0000_0102);
        repeat (8) step();
        check("odd_req", log_at(0), 32'h0000_0100);

        // Redirect while a slow fetch is outstanding
        wait_fix = 3;
        seen  = req_starts;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (req_starts != seen) found = 1'b1;
        end
        check("wait_req_seen", 32'(found), 32'h1);
        old_addr = imem_addr;
        step();
        do_redirect(32'h0000_0200);
        @(negedge sck);
        check("wait_addr_held", imem_addr, old_addr);
        check("wait_req_held", 32'(imem_req), 32'h1);
        check("wait_flushed", 32'(cmd_valid), 32'h0);
        repeat (16) step();
        check("wait_new_req", log_at(0), 32'h0000_0200);

        // Redirect coinciding with ack and pop
        wait_fix  = 0;
        cmd_ready = 1'b1;
        repeat (6) step();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (imem_ack && cmd_valid && cmd_ready) begin
                found = 1'b1;
                do_redirect(32'h0000_0300);
            end
        end
        check("coinc_seen", 32'(found), 32'h1);
        @(negedge sck);
        check("coinc_empty", 32'(cmd_valid), 32'h0);
        check("coinc_req", 32'(imem_req), 32'h1);
        check("coinc_addr", imem_addr, 32'h0000_0300);
        repeat (8) step();

        // Address wrap-around
        do_redirect(32'hFFFF_FFFC);
        repeat (10) step();
        check("wrap_req0", log_at(0), 32'hFFFF_FFFC);
        check("wrap_req1", log_at(1), 32'h0000_0000);

        // Random traffic: wait states, backpressure and redirects
        wait_fix = -1;
        wait_max = 3;
        base_hs  = hs_count;
        for (int i = 0; i < 3000; i++) begin
            step();
            cmd_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(23, 0) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                         : $urandom;
            end else begin
                redirect = 1'b0;
            end
        end
        step();
        redirect = 1'b0;
        repeat (10) step();
        check("rand_progress", 32'(hs_count - base_hs > 500), 32'h1);

        // Reset in the middle of operation
        wait_fix  = 0;
        cmd_ready = 1'b1;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'h0);
        check("mid_rst_addr", imem_addr, RESET_PC & 32'hFFFF_FFFC);
        check("mid_rst_cmd", 32'(cmd), 32'h0);
        check("mid_rst_valid", 32'(cmd_valid), 32'h0);
        check("mid_rst_cmd_pc", cmd_pc, RESET_PC & 32'hFFFF_FFFE);
        repeat (2) @(negedge sck);
        rst_n = 1'b1;
        @(negedge sck);
        check("mid_rst_refetch", 32'(imem_req), 32'h1);
        check("mid_rst_refetch_addr", imem_addr, RESET_PC & 32'hFFFF_FFFC);
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
